tri_uart_reader: RTL

TRI_UART_READER -- requirements
Module: tri_uart_reader

---
 rtl/tri_buffer_pkg.sv | 38 +++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/tri_uart_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tri_buffer_pkg.sv
// Shared definitions for the triple-buffer capture/transmit slice: buffer and
// selection codes, the UART reader state encoding and default strobe levels.
package tri_buffer_pkg;

    typedef enum logic [1:0] {
        BUF_X = 2'd0,
        BUF_Y = 2'd1,
        BUF_Z = 2'd2
    } buf_e;

    typedef enum logic [2:0] {
        SEL_A = 3'd0,
        SEL_B = 3'd1,
        SEL_C = 3'd2,
        SEL_D = 3'd3,
        SEL_E = 3'd4,
        SEL_F = 3'd5
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_GAP   = 3'd6
    } rd_state_e;

    localparam logic TRANS_ACTIVE_DEF = 1'b0;
    localparam logic CAP_ACTIVE_DEF   = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period divider: bit_tick_o marks the last cycle of each
// CLKS_PER_BIT-long bit while enabled; the count is held at zero when disabled.
module uart_bit_timer
    import tri_buffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/tri_uart_reader.sv
// Reads FRAME_BYTES bytes from the transmit-side buffer and sends them as a
// back-to-back UART 8N1 stream, then holds trans_trigger for the buffer-switch gap.
module tri_uart_reader
    import tri_buffer_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 868,
    parameter int   FRAME_BYTES  = 64,
    parameter int   ADDR_W       = 6,
    parameter int   GAP_CYCLES   = 16,
    parameter logic TRANS_ACTIVE = TRANS_ACTIVE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              trans_trigger,
    output logic              busy,
    output logic              byte_done,
    output rd_state_e         state_o
);

    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);

    rd_state_e         state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              tx_q, tx_d;
    logic              timer_en;
    logic              bit_tick;

    assign timer_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .en_i       (timer_en),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        tx_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            // rd_en is high here; the buffer returns rd_data during LOAD.
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d = rd_data;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_FETCH) addr_d = idx_d;

        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            gap_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
        end
    end

    assign rd_en         = (state_q == ST_FETCH);
    assign rd_addr       = addr_q;
    assign tx            = tx_q;
    assign busy          = (state_q != ST_IDLE);
    assign byte_done     = (state_q == ST_STOP) && bit_tick;
    assign trans_trigger = (state_q == ST_GAP) ? TRANS_ACTIVE : ~TRANS_ACTIVE;
    assign state_o       = state_q;

endmodule
